rv_instr_encoder: RTL and testbench
===================================

Name: rv_instr_encoder

Overview:
- Encodes symbolic RV32I operations into 32-bit instruction words and writes them sequentially into instruction memory.
- Covers the same instruction subset as the core's control decoder: ADD, SUB, OR, AND, SLT, ADDI, ORI, ANDI, LW, SW, BEQ, JAL, JALR, LUI.
- Used as the program loader: a host streams ops in; the block buffers the encoded words in a FIFO and drains them to the imem write port with an address counter.

Parameters:
DEPTH, 4, encoded-word FIFO entries (power of 2, ≥2)
ADDR_WIDTH, 32, imem byte-address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: begin a load at base_addr
base_addr  in  ADDR_WIDTH  first byte address written
in_valid  in  1  op request valid
in_ready  out  1  encoder can accept an op
in_op  in  4  op code: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 SLT, 5 ADDI, 6 ORI, 7 ANDI, 8 LW, 9 SW, 10 BEQ, 11 JAL, 12 JALR, 13 LUI; 14–15 illegal
in_rd, in_rs1, in_rs2  in  5 each  register fields
in_imm  in  32  immediate; for LUI, the full 32-bit value (upper 20 bits used)
in_last  in  1  marks the final op of the program
imem_we  out  1  write request
imem_addr  out  ADDR_WIDTH  write byte address
imem_wdata  out  32  encoded instruction
imem_ack  in  1  memory accepted the write this cycle
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse when the load completes
err  out  1  sticky illegal-op flag; cleared by start
count  out  16  words written since start

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; FIFO emptied.
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, count=0.
- States: IDLE → LOAD → DRAIN → DONE → IDLE.
- IDLE:
  - in_ready=0.
  - start=1 → LOAD; addr<=base_addr, count<=0, err<=0.
  - start is ignored in every other state.
- LOAD:
  - in_ready = !fifo_full. There is no pass-through when full.
  - An accept is in_valid & in_ready.
  - The encoded word is pushed at the accepting clock edge and appears at the FIFO head no earlier than the next cycle (1-cycle encode latency).
  - Illegal op (14–15): still accepted, not pushed, err<=1.
  - An accept with in_last=1 → DRAIN, including when that op is illegal.
- DRAIN:
  - in_ready=0.
  - When the FIFO is empty → DONE.
- DONE:
  - done=1 for exactly one cycle, then → IDLE.
- Write side (active in LOAD and DRAIN):
  - imem_we = fifo not empty; imem_wdata = head word; imem_addr = addr.
  - Address and data are held stable while imem_we=1 and imem_ack=0.
  - On imem_we & imem_ack: pop the FIFO; addr<=addr+4, wrapping mod 2^ADDR_WIDTH; count<=count+1, wrapping at 16 bits.
  - imem_ack is ignored when imem_we=0.
- Push and pop in the same cycle: both take effect and occupancy is unchanged.
- Encoding (opcode in [6:0], rd in [11:7], funct3 in [14:12], rs1 in [19:15], rs2 in [24:20]):
  - R-type, opcode 0110011, funct7 0000000 except SUB 0100000: ADD f3=000, SUB 000, OR 110, AND 111, SLT 010.
  - I-type, [31:20]=imm[11:0]: ADDI 0010011/000, ORI 0010011/110, ANDI 0010011/111, LW 0000011/010, JALR 1100111/000.
  - S-type SW 0100011/010: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B-type BEQ 1100011/000: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. imm[0] is ignored.
  - J-type JAL 1101111: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. imm[0] is ignored.
  - U-type LUI 0110111: [31:12]=imm[31:12].
  - Fields unused by a format are ignored. Immediate bits above a format's range are dropped with no range check.
- Reset asserted mid-load: all state returns to the reset values and the FIFO contents are discarded. No further imem writes occur.

Test Plan:
- start, base_addr=0x100; ADD rd3,rs1=1,rs2=2 then SUB with the same fields and in_last=1:
  - writes 0x002081B3 @0x100 and 0x402081B3 @0x104;
  - done pulses once; count=2; err=0.
- ADDI rd5,rs1=0,imm=-1 → 0xFFF00293; LW rd6,rs1=2,imm=8 → 0x00812303; SW rs2=6,rs1=2,imm=12 → 0x00612623.
- BEQ rs1=1,rs2=2,imm=-8 → 0xFE208CE3; JAL rd1,imm=0x800 → 0x001000EF; LUI rd7,imm=0x12345000 → 0x123453B7.
- imem_ack held 0, DEPTH=4, 5 ops offered:
  - exactly 4 accepted, then in_ready=0;
  - imem_addr and imem_wdata stay at the first entry;
  - after ack is released, all 5 words are written at consecutive addresses.
- op=15 between two legal ops:
  - err=1 and stays 1 after done; only 2 writes; count=2;
  - the next start clears err.
- rst_n pulled low with 3 words buffered:
  - outputs go immediately to the reset values; no writes afterwards; busy=0;
  - a new start at base_addr=0xFFFFFFFC followed by 2 ops wraps the address: writes @0xFFFFFFFC then @0x0.

Source files
------------

// File: rtl/rv_instr_encoder.sv
// RV32I program loader. Ops are encoded into a DEPTH-entry FIFO at the accepting edge and written to imem one cycle later at the earliest.
// Backpressure: in_ready drops when the FIFO is full; each write holds addr/data until imem_ack.
module rv_instr_encoder #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_op,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [31:0]           in_imm,
   input  logic                  in_last,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   input  logic                  imem_ack,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [15:0]           count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]           PTR_ONE   = 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = 4;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

   state_e                state_q, state_d;
   logic [PW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
   logic [31:0]           mem_q [DEPTH];
   logic [31:0]           mem_d [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  err_q, err_d;

   logic        fifo_empty, fifo_full;
   logic        accept, push, pop, legal;
   logic [31:0] enc_word;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

   always_comb begin
      legal    = 1'b1;
      enc_word = '0;
      case (in_op)
         4'd0:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
         4'd1:  enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
         4'd2:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, 7'b0110011};
         4'd3:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, 7'b0110011};
         4'd4:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b010, in_rd, 7'b0110011};
         4'd5:  enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
         4'd6:  enc_word = {in_imm[11:0], in_rs1, 3'b110, in_rd, 7'b0010011};
         4'd7:  enc_word = {in_imm[11:0], in_rs1, 3'b111, in_rd, 7'b0010011};
         4'd8:  enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
         4'd9:  enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
         4'd10: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                            in_imm[4:1], in_imm[11], 7'b1100011};
         4'd11: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, 7'b1101111};
         4'd12: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
         4'd13: enc_word = {in_imm[31:12], in_rd, 7'b0110111};
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      mem_d   = mem_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      in_ready = (state_q == S_LOAD) && !fifo_full;
      accept   = in_valid && in_ready;
      push     = accept && legal;
      imem_we  = ((state_q == S_LOAD) || (state_q == S_DRAIN)) && !fifo_empty;
      pop      = imem_we && imem_ack;

      if (push) begin
         mem_d[wptr_q[PW-1:0]] = enc_word;
         wptr_d                = wptr_q + PTR_ONE;
      end
      if (accept && !legal) begin
         err_d = 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + PTR_ONE;
         addr_d = addr_q + ADDR_STEP;
         cnt_d  = cnt_q + 16'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               addr_d  = base_addr;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         S_LOAD:  if (accept && in_last) state_d = S_DRAIN;
         S_DRAIN: if (fifo_empty) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         mem_q   <= mem_d;
      end
   end

   assign imem_addr  = addr_q;
   assign imem_wdata = imem_we ? mem_q[rptr_q[PW-1:0]] : 32'h0;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign err        = err_q;
   assign count      = cnt_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder: hand-encoded words, backpressure, illegal ops, reset and address wrap.
module tb_rv_instr_encoder;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] base_addr;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;
   logic        in_last;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        imem_ack;
   logic        busy, done, err;
   logic [15:0] count;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] wr_addr [64];
   logic [31:0] wr_dat  [64];
   int          n_wr     = 0;
   int          done_cnt = 0;

   rv_instr_encoder #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .imem_ack(imem_ack), .busy(busy), .done(done), .err(err), .count(count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Writes commit on the next rising edge; inputs are stable from negedge to then.
   always @(negedge clk) begin
      if (imem_we && imem_ack && n_wr < 64) begin
         wr_addr[n_wr] = imem_addr;
         wr_dat[n_wr]  = imem_wdata;
         n_wr++;
      end
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   task automatic do_start(input logic [31:0] b);
      start     = 1'b1;
      base_addr = b;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   task automatic send_op(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm, input logic last);
      int t;
      bit acc;
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_imm = imm; in_last = last;
      t = 0; acc = 1'b0;
      while (!acc && t < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         t++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done();
      int t;
      bit seen;
      t = 0; seen = 1'b0;
      while (!seen && t < 100) begin
         @(negedge clk);
         seen = done;
         @(posedge clk); #1;
         t++;
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
   endtask

   logic [31:0] vec_exp [6];
   logic [31:0] bp_exp  [5];
   int base_wr;
   int acc_n;

   initial begin
      vec_exp = '{32'hFFF00293, 32'h00812303, 32'h00612623,
                  32'hFE208CE3, 32'h001000EF, 32'h123453B7};
      bp_exp  = '{32'h002080B3, 32'h00208133, 32'h002081B3,
                  32'h00208233, 32'h002082B3};
      rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_op = '0;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0; imem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
      chk("rst_imem_addr", imem_addr, 32'd0);
      chk("rst_imem_wdata", imem_wdata, 32'd0);
      chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
      chk("rst_count", {16'd0, count}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

      // ADD then SUB
      imem_ack = 1'b1; done_cnt = 0; base_wr = n_wr;
      do_start(32'h100);
      chk("start_busy", {31'd0, busy}, 32'd1);
      send_op(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      send_op(4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
      wait_done();
      repeat (3) @(posedge clk);
      #1;
      chk("t1_nwr", n_wr - base_wr, 32'd2);
      chk("t1_addr0", wr_addr[base_wr], 32'h100);
      chk("t1_dat0", wr_dat[base_wr], 32'h002081B3);
      chk("t1_addr1", wr_addr[base_wr+1], 32'h104);
      chk("t1_dat1", wr_dat[base_wr+1], 32'h402081B3);
      chk("t1_done_once", done_cnt, 32'd1);
      chk("t1_count", {16'd0, count}, 32'd2);
      chk("t1_err", {31'd0, err}, 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd0);

      // Immediate formats
      base_wr = n_wr;
      do_start(32'h200);
      send_op(4'd5,  5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
      send_op(4'd8,  5'd6, 5'd2, 5'd0, 32'd8,        1'b0);
      send_op(4'd9,  5'd0, 5'd2, 5'd6, 32'd12,       1'b0);
      send_op(4'd10, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 1'b0);
      send_op(4'd11, 5'd1, 5'd0, 5'd0, 32'h800,      1'b0);
      send_op(4'd13, 5'd7, 5'd0, 5'd0, 32'h12345000, 1'b1);
      wait_done();
      chk("t2_nwr", n_wr - base_wr, 32'd6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t2_dat%0d", i), wr_dat[base_wr+i], vec_exp[i]);
      end
      chk("t2_addr5", wr_addr[base_wr+5], 32'h214);

      // Backpressure: ack held low while 5 ops are offered
      imem_ack = 1'b0; base_wr = n_wr;
      do_start(32'h300);
      acc_n = 0;
      for (int c = 0; c < 10; c++) begin
         in_valid = (acc_n < 5);
         in_op = 4'd0; in_rd = 5'(acc_n + 1); in_rs1 = 5'd1; in_rs2 = 5'd2; in_last = 1'b0;
         @(negedge clk);
         if (in_valid && in_ready) acc_n++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("bp_accepted", acc_n, 32'd4);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_we", {31'd0, imem_we}, 32'd1);
      chk("bp_addr_hold", imem_addr, 32'h300);
      chk("bp_wdata_hold", imem_wdata, 32'h002080B3);
      chk("bp_no_writes", n_wr - base_wr, 32'd0);
      imem_ack = 1'b1;
      send_op(4'd0, 5'd5, 5'd1, 5'd2, 32'd0, 1'b1);
      wait_done();
      chk("bp_nwr", n_wr - base_wr, 32'd5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_addr%0d", i), wr_addr[base_wr+i], 32'h300 + 32'(4*i));
         chk($sformatf("bp_dat%0d", i), wr_dat[base_wr+i], bp_exp[i]);
      end

      // Illegal op between two legal ops
      base_wr = n_wr;
      do_start(32'h400);
      send_op(4'd0,  5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      send_op(4'd15, 5'd9, 5'd9, 5'd9, 32'd0, 1'b0);
      send_op(4'd1,  5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
      wait_done();
      repeat (2) @(posedge clk);
      #1;
      chk("ill_err", {31'd0, err}, 32'd1);
      chk("ill_nwr", n_wr - base_wr, 32'd2);
      chk("ill_count", {16'd0, count}, 32'd2);
      chk("ill_dat1", wr_dat[base_wr+1], 32'h402081B3);
      chk("ill_addr1", wr_addr[base_wr+1], 32'h404);

      // Next start clears err; then reset mid-load with 3 words buffered
      imem_ack = 1'b0;
      do_start(32'h500);
      chk("start_clr_err", {31'd0, err}, 32'd0);
      send_op(4'd0, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0);
      send_op(4'd0, 5'd2, 5'd1, 5'd2, 32'd0, 1'b0);
      send_op(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      chk("pre_rst_we", {31'd0, imem_we}, 32'd1);
      base_wr = n_wr;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
      chk("mid_rst_addr", imem_addr, 32'd0);
      chk("mid_rst_wdata", imem_wdata, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      imem_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_no_writes", n_wr - base_wr, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_count", {16'd0, count}, 32'd0);

      // Address wrap
      base_wr = n_wr;
      do_start(32'hFFFFFFFC);
      send_op(4'd6, 5'd1, 5'd1, 5'd0, 32'h0F0, 1'b0);
      send_op(4'd7, 5'd2, 5'd2, 5'd0, 32'h0FF, 1'b1);
      wait_done();
      chk("wrap_nwr", n_wr - base_wr, 32'd2);
      chk("wrap_addr0", wr_addr[base_wr], 32'hFFFFFFFC);
      chk("wrap_dat0", wr_dat[base_wr], 32'h0F00E093);
      chk("wrap_addr1", wr_addr[base_wr+1], 32'h0);
      chk("wrap_dat1", wr_dat[base_wr+1], 32'h0FF17113);
      chk("wrap_count", {16'd0, count}, 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
